// File: rtl/sev_seg_pkg.sv
// Shared types and default timing for the seven-segment display scheduler.
package sev_seg_pkg;

  typedef enum logic {S_BLANK, S_ON} sched_state_t;

  typedef logic [3:0] digit_t;

  // 6 MHz clock: 30000 cycles = 200 Hz per digit slot, 600 cycles = 100 us dead time
  localparam int unsigned DEF_NUM_DIGITS  = 2;
  localparam int unsigned DEF_REFRESH_DIV = 30000;
  localparam int unsigned DEF_DEADTIME    = 600;

endpackage

// File: rtl/sev_seg_phase_timer.sv
// Down-counter that times one scheduler phase; done is high on the last cycle
// of the phase, when the counter reloads with the length of the next phase.
module sev_seg_phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] len,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt == W'(1));

  // A zero count only occurs straight after reset; it starts the first phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == '0 || done) begin
      cnt <= len;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sev_seg_scheduler.sv
// Time-multiplexes stored keypad digits onto shared seven-segment pins with
// an all-off dead time at each digit switch. Option: SEG_BLANK_UNLOADED_EN.
module sev_seg_scheduler
  import sev_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int unsigned DEADTIME    = DEF_DEADTIME
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          key_ready,
  output logic [NUM_DIGITS-1:0]         seg_en,
  output logic [3:0]                    sw,
  output logic [$clog2(NUM_DIGITS)-1:0] slot
);

  localparam int unsigned SW_W   = $clog2(NUM_DIGITS);
  localparam int unsigned TW     = $clog2(REFRESH_DIV + 1);
  localparam int unsigned ON_LEN = REFRESH_DIV - DEADTIME;

  if (DEADTIME < 1 || REFRESH_DIV <= DEADTIME || NUM_DIGITS < 2) begin : g_bad_params
    $error("sev_seg_scheduler: need DEADTIME>=1, REFRESH_DIV>DEADTIME, NUM_DIGITS>=2");
  end

  sched_state_t          state;
  sched_state_t          state_nxt;
  logic                  phase_done;
  logic [TW-1:0]         phase_len;
  logic                  transfer;
  logic [NUM_DIGITS-1:0] on_mask;
  digit_t                digit [NUM_DIGITS];

  // Reload length is for the phase being entered; the post-reset start is a blank phase.
  assign phase_len = (state == S_BLANK && phase_done) ? TW'(ON_LEN) : TW'(DEADTIME);

  sev_seg_phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .len   (phase_len),
    .done  (phase_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_BLANK: if (phase_done) state_nxt = S_ON;
      S_ON:    if (phase_done) state_nxt = S_BLANK;
      default: state_nxt = S_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  assign key_ready = (state == S_BLANK);
  assign transfer  = key_valid && key_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digit[i] <= '0;
      end
    end else if (transfer) begin
      digit[0] <= key_code;
      for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
        digit[i] <= digit[i-1];
      end
    end
  end

`ifdef SEG_BLANK_UNLOADED_EN
  logic [NUM_DIGITS-1:0] loaded;
  logic [NUM_DIGITS-1:0] loaded_nxt;

  assign loaded_nxt = transfer ? {loaded[NUM_DIGITS-2:0], 1'b1} : loaded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded <= '0;
    end else begin
      loaded <= loaded_nxt;
    end
  end

  // Uses the post-transfer flags so a load on the final blank cycle lights at once.
  always_comb begin
    on_mask       = '0;
    on_mask[slot] = loaded_nxt[slot];
  end
`else
  always_comb begin
    on_mask       = '0;
    on_mask[slot] = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot   <= '0;
      seg_en <= '0;
    end else if (phase_done) begin
      if (state == S_BLANK) begin
        seg_en <= on_mask;
      end else begin
        seg_en <= '0;
        slot   <= (slot == SW_W'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
      end
    end
  end

  assign sw = digit[slot];

endmodule

// File: tb/tb_sev_seg_scheduler.sv
// Directed bench for sev_seg_scheduler with a cycle model and expectation queue.
module tb_sev_seg_scheduler;

  localparam int ND = 2;
  localparam int RD = 10;
  localparam int DT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          key_ready;
  logic [ND-1:0] seg_en;
  logic [3:0]    sw;
  logic          slot;

  always #5 clk = ~clk;

  sev_seg_scheduler #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEADTIME    (DT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .seg_en    (seg_en),
    .sw        (sw),
    .slot      (slot)
  );

  typedef struct packed {
    logic [ND-1:0] en;
    logic [3:0]    sw;
    logic          rdy;
    logic          sl;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: e = edges since reset release (-1 before the first one).
  int            e = -1;
  bit            in_rst = 1'b1;
  bit            took = 1'b0;
  logic [3:0]    md [ND];
  logic [ND-1:0] mload = '0;
  logic [ND-1:0] prev_en = '0;
  logic [3:0]    prev_sw = '0;

  function automatic bit m_on(int ee);
    return (ee >= 0) && ((ee % RD) >= DT);
  endfunction

  function automatic int m_slot(int ee);
    return (ee < 0) ? 0 : (ee / RD) % ND;
  endfunction

  task automatic cmp(string tag, logic [7:0] obs, logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    int   s;
    s     = m_slot(e);
    x.en  = '0;
`ifdef SEG_BLANK_UNLOADED_EN
    if (m_on(e)) x.en[s] = mload[s];
`else
    if (m_on(e)) x.en[s] = 1'b1;
`endif
    x.sw  = md[s];
    x.rdy = !m_on(e);
    x.sl  = 1'(s);
    sbq.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    x = sbq.pop_front();
    cmp("seg_en",    8'(seg_en),    8'(x.en));
    cmp("sw",        8'(sw),        8'(x.sw));
    cmp("key_ready", 8'(key_ready), 8'(x.rdy));
    cmp("slot",      8'(slot),      8'(x.sl));
    cmp("onehot0",   8'($onehot0(seg_en)), 8'd1);
    if (seg_en != '0 && seg_en == prev_en) cmp("sw_stable", 8'(sw), 8'(prev_sw));
    prev_en = seg_en;
    prev_sw = sw;
  endtask

  task automatic step();
    @(posedge clk);
    took = 1'b0;
    if (!in_rst) begin
      if (key_valid && !m_on(e)) begin
        for (int i = ND - 1; i > 0; i--) begin
          md[i]    = md[i-1];
          mload[i] = mload[i-1];
        end
        md[0]    = key_code;
        mload[0] = 1'b1;
        took     = 1'b1;
      end
      e++;
    end
    push_exp();
    @(negedge clk);
    check_out();
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 200 && e < target; i++) step();
  endtask

  task automatic offer(logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    took      = 1'b0;
    for (int i = 0; i < 2 * RD && !took; i++) step();
    key_valid = 1'b0;
  endtask

  task automatic model_reset();
    in_rst = 1'b1;
    e      = -1;
    mload  = '0;
    for (int i = 0; i < ND; i++) md[i] = 4'h0;
  endtask

  initial begin
    model_reset();
    // Power-on reset, then free-running rotation with no keys.
    repeat (3) step();
    reset  = 1'b1;
    in_rst = 1'b0;
    run_to(19);

    // Two keys in the blank phase; the second lands on the final blank cycle.
    run_to(20);
    offer(4'h5);
    offer(4'hA);
    run_to(44);

    // Request raised while a digit is lit waits for the next blank phase.
    offer(4'h3);
    run_to(66);

    // Asynchronous reset in mid-slot clears outputs without a clock edge.
    reset = 1'b0;
    #1;
    model_reset();
    push_exp();
    check_out();
    repeat (2) step();
    reset  = 1'b1;
    in_rst = 1'b0;
    run_to(25);
    offer(4'h7);
    run_to(45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
